mul16_accum: RTL and testbench
==============================

MUL16_ACCUM -- requirements
Module: mul16_accum

Interface
REQ-001 Parameter LEN_W, default 8: width of the vector-length field.
REQ-002 Parameter ACC_W, default 40: width of the signed accumulator and result, in Q(ACC_W-31).30 format.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-high reset; sampled on the clk rising edge; asserted = 1.
REQ-005 start  input  1  one-cycle strobe that begins a dot-product job.
REQ-006 prec  input  2  precision select, sampled with start: 0 = Q1.6, 1 = Q1.14, 2 = Q1.30, 3 = reserved.
REQ-007 vec_len  input  LEN_W  number of products to accumulate, sampled with start.
REQ-008 abort  input  1  cancels the job in progress.
REQ-009 q1_6_in / q1_6_valid  input  8 / 1  signed Q1.6 product and its strobe from the upstream multiplier.
REQ-010 q1_14_in / q1_14_valid  input  16 / 1  signed Q1.14 product and its strobe.
REQ-011 q1_30_in / q1_30_valid  input  32 / 1  signed Q1.30 product and its strobe.
REQ-012 busy  output  1  high while in ACCUM.
REQ-013 out_data  output  ACC_W  signed accumulated result, Q.30 aligned.
REQ-014 out_valid  output  1  result available; held until accepted.
REQ-015 out_ready  input  1  downstream accepts out_data when out_valid and out_ready are both 1 in the same cycle.
REQ-016 sat_flag  output  1  set if any accumulate step of the current job saturated.
REQ-017 overrun  output  1  sticky error flag.

Function
REQ-018 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-019 IDLE, start=1: latch prec/vec_len, clear acc, count and sat_flag; go to ACCUM, or to DONE if vec_len=0 (out_data=0).
REQ-020 IDLE, start=1, prec=3: treat as prec=2.
REQ-021 ACCUM: only the strobe matching the latched prec is a term; the strobes of the other two precisions are ignored without error.
REQ-022 Term alignment to Q.30, sign-extended to ACC_W: Q1.6 = {sext(q1_6_in),24'b0}; Q1.14 = {sext(q1_14_in),16'b0}; Q1.30 = sext(q1_30_in).
REQ-023 Each term SHALL add to acc in the cycle its strobe is sampled; the result SHALL saturate to the signed ACC_W range and set sat_flag on saturation.
REQ-024 count increments once per accepted term; the accepted term with count reaching vec_len updates acc and transitions to DONE the next cycle.
REQ-025 Latency: out_valid rises one cycle after the clock edge that samples the last term.
REQ-026 DONE: out_valid=1, and out_data and sat_flag are held stable until handshake; on handshake return to IDLE with out_valid=0 next cycle.
REQ-027 start in ACCUM or DONE is ignored.
REQ-028 start in the same cycle as a DONE handshake is ignored; the new job requires start in IDLE.
REQ-029 A selected-precision strobe in IDLE or DONE SHALL set overrun (sticky until reset) and SHALL NOT change acc.
REQ-030 abort in ACCUM: go to IDLE next cycle, discard acc, no out_valid.
REQ-031 abort in IDLE or DONE: no effect; abort has priority over a same-cycle term.
REQ-032 busy=1 exactly while in ACCUM.

Reset
REQ-033 rst_n=1 at a clock edge forces IDLE, acc=0, count=0, out_data=0, out_valid=0, busy=0, sat_flag=0, overrun=0, regardless of state, including mid-job or with out_valid pending.
REQ-034 Input strobes in the reset cycle are discarded.

Verification
REQ-035 Q1.6 job: start, prec=0, vec_len=3; q1_6_in=0x40,0x20,0xE0 -> out_valid 1 cycle after 3rd term; out_data=0x0040000000; sat_flag=0.
REQ-036 Q1.30 job: vec_len=2; q1_30_in=0x40000000,0xC0000000 -> out_data=0; q1_14_valid pulses during the job ignored; overrun=0.
REQ-037 Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data stable; extra q1_30_valid in DONE sets overrun=1; accept returns busy=0 and out_valid=0.
REQ-038 Saturation with ACC_W=32: Q1.30, vec_len=3, three terms of 0x40000000 -> out_data=0x7FFFFFFF; sat_flag=1.
REQ-039 vec_len=0 -> DONE one cycle after start with out_data=0; abort after 2 of 4 terms -> IDLE, no out_valid; rst_n=1 mid-job -> every output at its REQ-033 value.

Source files
------------

// File: rtl/mul16_accum.sv
// Mixed-precision dot-product accumulator: sums Q1.6/Q1.14/Q1.30 products into a
// saturating Q.30-aligned accumulator and hands the result off with a valid/ready handshake.
module mul16_accum #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       prec,
  input  logic [LEN_W-1:0] vec_len,
  input  logic             abort,
  input  logic [7:0]       q1_6_in,
  input  logic             q1_6_valid,
  input  logic [15:0]      q1_14_in,
  input  logic             q1_14_valid,
  input  logic [31:0]      q1_30_in,
  input  logic             q1_30_valid,
  output logic             busy,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sat_flag,
  output logic             overrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [1:0]       prec_q, prec_d;
  logic             sat_q, sat_d;
  logic             overrun_q, overrun_d;

  logic signed [ACC_W-1:0] term_6, term_14, term_30;
  logic [ACC_W-1:0]        term;
  logic                    term_valid;
  logic [ACC_W:0]          sum;
  logic                    sum_ovf;
  logic [ACC_W-1:0]        sum_sat;
  logic [LEN_W-1:0]        count_inc;

  // Align every precision to a common Q.30 binary point.
  always_comb begin
    term_6  = ACC_W'($signed(q1_6_in)) <<< 24;
    term_14 = ACC_W'($signed(q1_14_in)) <<< 16;
    term_30 = ACC_W'($signed(q1_30_in));
    case (prec_q)
      2'd0: begin
        term       = term_6;
        term_valid = q1_6_valid;
      end
      2'd1: begin
        term       = term_14;
        term_valid = q1_14_valid;
      end
      default: begin
        term       = term_30;
        term_valid = q1_30_valid;
      end
    endcase
    sum       = {acc_q[ACC_W-1], acc_q} + {term[ACC_W-1], term};
    sum_ovf   = sum[ACC_W] != sum[ACC_W-1];
    sum_sat   = sum_ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
    count_inc = count_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    len_d     = len_q;
    prec_d    = prec_q;
    sat_d     = sat_q;
    overrun_d = overrun_q;
    case (state_q)
      S_IDLE: begin
        if (term_valid) overrun_d = 1'b1;
        if (start) begin
          prec_d  = (prec == 2'd3) ? 2'd2 : prec;
          len_d   = vec_len;
          acc_d   = '0;
          count_d = '0;
          sat_d   = 1'b0;
          state_d = (vec_len == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        // Abort wins over a term arriving in the same cycle.
        if (abort) begin
          state_d = S_IDLE;
          acc_d   = '0;
          count_d = '0;
        end else if (term_valid) begin
          acc_d   = sum_sat;
          sat_d   = sat_q | sum_ovf;
          count_d = count_inc;
          if (count_inc == len_q) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (term_valid) overrun_d = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      count_q   <= '0;
      len_q     <= '0;
      prec_q    <= 2'd0;
      sat_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      len_q     <= len_d;
      prec_q    <= prec_d;
      sat_q     <= sat_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy      = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = acc_q;
  assign sat_flag  = sat_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_mul16_accum.sv
// Directed bench for mul16_accum: a 40-bit instance for the main jobs and a 32-bit
// instance fed the same stimulus for the saturation case.
module tb_mul16_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  prec;
  logic [7:0]  vec_len;
  logic        abort;
  logic [7:0]  q1_6_in;
  logic        q1_6_valid;
  logic [15:0] q1_14_in;
  logic        q1_14_valid;
  logic [31:0] q1_30_in;
  logic        q1_30_valid;
  logic        out_ready;

  logic        busy, out_valid, sat_flag, overrun;
  logic [39:0] out_data;
  logic        busy32, out_valid32, sat_flag32, overrun32;
  logic [31:0] out_data32;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul16_accum #(.LEN_W(8), .ACC_W(40)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prec(prec), .vec_len(vec_len),
    .abort(abort), .q1_6_in(q1_6_in), .q1_6_valid(q1_6_valid),
    .q1_14_in(q1_14_in), .q1_14_valid(q1_14_valid),
    .q1_30_in(q1_30_in), .q1_30_valid(q1_30_valid),
    .busy(busy), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .sat_flag(sat_flag), .overrun(overrun)
  );

  mul16_accum #(.LEN_W(8), .ACC_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start), .prec(prec), .vec_len(vec_len),
    .abort(abort), .q1_6_in(q1_6_in), .q1_6_valid(q1_6_valid),
    .q1_14_in(q1_14_in), .q1_14_valid(q1_14_valid),
    .q1_30_in(q1_30_in), .q1_30_valid(q1_30_valid),
    .busy(busy32), .out_data(out_data32), .out_valid(out_valid32),
    .out_ready(out_ready), .sat_flag(sat_flag32), .overrun(overrun32)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [1:0] p, input logic [7:0] len);
    start = 1'b1; prec = p; vec_len = len;
    tick();
    start = 1'b0;
  endtask

  task automatic term30(input logic [31:0] v);
    q1_30_valid = 1'b1; q1_30_in = v;
    tick();
    q1_30_valid = 1'b0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; prec = 2'd0; vec_len = 8'd0; abort = 1'b0;
    q1_6_in = '0; q1_6_valid = 1'b0; q1_14_in = '0; q1_14_valid = 1'b0;
    q1_30_in = '0; q1_30_valid = 1'b0; out_ready = 1'b0;
    #2;
    tick(); tick();
    rst_n = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_sat", 64'(sat_flag), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);

    // Q1.6 job: 1.0 + 0.5 - 0.5
    start_job(2'd0, 8'd3);
    check("q6_busy", 64'(busy), 64'd1);
    q1_6_valid = 1'b1;
    q1_6_in = 8'h40; tick();
    q1_6_in = 8'h20; tick();
    check("q6_not_done_yet", 64'(out_valid), 64'd0);
    q1_6_in = 8'hE0; tick();
    q1_6_valid = 1'b0;
    check("q6_out_valid", 64'(out_valid), 64'd1);
    check("q6_busy_done", 64'(busy), 64'd0);
    check("q6_out_data", 64'(out_data), 64'h0040000000);
    check("q6_sat", 64'(sat_flag), 64'd0);
    accept();
    check("q6_accept_valid", 64'(out_valid), 64'd0);

    // Q1.30 job with off-precision strobes mixed in
    start_job(2'd2, 8'd2);
    q1_14_valid = 1'b1; q1_14_in = 16'h4000;
    term30(32'h40000000);
    tick();
    term30(32'hC0000000);
    q1_14_valid = 1'b0;
    check("q30_out_valid", 64'(out_valid), 64'd1);
    check("q30_out_data", 64'(out_data), 64'd0);
    check("q30_overrun", 64'(overrun), 64'd0);
    accept();

    // Q1.14 job with a negative term: -1.0 + 0.5
    start_job(2'd1, 8'd2);
    q1_14_valid = 1'b1;
    q1_14_in = 16'hC000; tick();
    q1_14_in = 16'h2000; tick();
    q1_14_valid = 1'b0;
    check("q14_out_data", 64'(out_data), 64'hFFE0000000);
    accept();

    // prec=3 behaves as Q1.30; a Q1.6 strobe alongside is ignored
    start_job(2'd3, 8'd1);
    q1_6_valid = 1'b1; q1_6_in = 8'h7F;
    term30(32'h12345678);
    q1_6_valid = 1'b0;
    check("prec3_out_data", 64'(out_data), 64'h0012345678);
    check("prec3_overrun", 64'(overrun), 64'd0);
    accept();

    // Backpressure, overrun in DONE, start ignored in DONE
    start_job(2'd2, 8'd2);
    term30(32'h20000000);
    term30(32'h10000000);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        q1_30_valid = 1'b1; q1_30_in = 32'h7FFFFFFF;
      end
      if (i == 3) begin
        start = 1'b1; vec_len = 8'd0;
      end
      tick();
      q1_30_valid = 1'b0; start = 1'b0;
      check($sformatf("bp_data_%0d", i), 64'(out_data), 64'h0030000000);
      check($sformatf("bp_valid_%0d", i), 64'(out_valid), 64'd1);
    end
    check("bp_overrun", 64'(overrun), 64'd1);
    accept();
    check("bp_accept_busy", 64'(busy), 64'd0);
    check("bp_accept_valid", 64'(out_valid), 64'd0);
    check("bp_overrun_sticky", 64'(overrun), 64'd1);

    // Saturation on the 32-bit instance; the 40-bit one still has headroom
    start_job(2'd2, 8'd3);
    term30(32'h40000000);
    term30(32'h40000000);
    term30(32'h40000000);
    check("sat32_valid", 64'(out_valid32), 64'd1);
    check("sat32_data", 64'(out_data32), 64'h7FFFFFFF);
    check("sat32_flag", 64'(sat_flag32), 64'd1);
    check("sat40_data", 64'(out_data), 64'h00C0000000);
    check("sat40_flag", 64'(sat_flag), 64'd0);
    accept();

    // Zero-length job completes immediately
    start_job(2'd0, 8'd0);
    check("len0_valid", 64'(out_valid), 64'd1);
    check("len0_data", 64'(out_data), 64'd0);
    check("len0_busy", 64'(busy), 64'd0);
    accept();

    // Abort after two of four terms, colliding with a third term
    start_job(2'd0, 8'd4);
    q1_6_valid = 1'b1; q1_6_in = 8'h10;
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0; q1_6_valid = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_data", 64'(out_data), 64'd0);
    tick(); tick();
    check("abort_valid_later", 64'(out_valid), 64'd0);

    // Reset mid-job with a strobe in the reset cycle
    start_job(2'd2, 8'd4);
    term30(32'h11111111);
    term30(32'h22222222);
    rst_n = 1'b1; q1_30_valid = 1'b1; q1_30_in = 32'h01000000;
    tick();
    rst_n = 1'b0; q1_30_valid = 1'b0;
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_valid", 64'(out_valid), 64'd0);
    check("mrst_data", 64'(out_data), 64'd0);
    check("mrst_sat", 64'(sat_flag), 64'd0);
    check("mrst_overrun", 64'(overrun), 64'd0);
    check("mrst_sat32", 64'(sat_flag32), 64'd0);

    // Selected-precision strobe while idle sets overrun and leaves acc alone
    start_job(2'd2, 8'd0);
    accept();
    term30(32'h01234567);
    check("idle_overrun", 64'(overrun), 64'd1);
    check("idle_data", 64'(out_data), 64'd0);
    check("idle_valid", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
